// File: rtl/riscv_pkg.sv
// Shared RV32 core definitions: widths, reset PC and PC helpers.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [ILEN-1:0] instr_t;

    // Registered IF/ID pipeline contents
    typedef struct packed {
        logic   valid;
        addr_t  pc;
        addr_t  pc_plus4;
        instr_t instr;
    } if_id_t;

    // Force word alignment of a fetch address
    function automatic addr_t pc_align(input addr_t pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    // Sequential successor, wraps mod 2^XLEN
    function automatic addr_t pc_inc(input addr_t pc);
        return pc + addr_t'(4);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding buffer for a fetch response that arrives while
// the IF/ID register is stalled. A valid entry is never overwritten.
module fetch_skid_buffer
    import riscv_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_load,
    input  logic   i_clear,
    input  addr_t  i_pc,
    input  instr_t i_instr,
    output logic   o_valid,
    output addr_t  o_pc,
    output instr_t o_instr
);

    logic   valid_q;
    addr_t  pc_q;
    instr_t instr_q;

    // Entry storage; clear wins over load, load ignored while occupied
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (i_clear) begin
            valid_q <= 1'b0;
        end else if (i_load && !valid_q) begin
            valid_q <= 1'b1;
            pc_q    <= i_pc;
            instr_q <= i_instr;
        end
    end

    assign o_valid = valid_q;
    assign o_pc    = pc_q;
    assign o_instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC generation, single outstanding imem request,
// one-entry skid for responses landing during a stall, IF/ID register.
// Redirect has priority over stall and discards all in-flight work.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_hazard_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ready,
    input  logic [ILEN-1:0] i_imem_rdata,
    output logic            o_if_id_valid,
    output logic [XLEN-1:0] o_if_id_pc,
    output logic [XLEN-1:0] o_if_id_pc_plus4,
    output logic [ILEN-1:0] o_if_id_instr
);

    addr_t  pc_f_q, pc_f_d;
    addr_t  resp_pc_q, resp_pc_d;
    logic   resp_pending_q, resp_pending_d;
    if_id_t if_id_q, if_id_d;

    logic   skid_load, skid_clear, skid_valid;
    addr_t  skid_pc;
    instr_t skid_instr;

    logic   req_int;
    logic   accept;

    // Request only depends on control inputs and skid occupancy, never on
    // returning data. Reset gating is applied at the port only, so the
    // state logic never sees the async reset as a data input.
    assign req_int     = !i_hazard_stall && !i_redirect_valid && !skid_valid;
    assign accept      = req_int && i_imem_ready;
    assign o_imem_req  = i_rst_n && req_int;
    assign o_imem_addr = pc_align(pc_f_q);

    fetch_skid_buffer u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (skid_load),
        .i_clear (skid_clear),
        .i_pc    (resp_pc_q),
        .i_instr (i_imem_rdata),
        .o_valid (skid_valid),
        .o_pc    (skid_pc),
        .o_instr (skid_instr)
    );

    // Next-state: redirect > stall > skid drain > live response > bubble
    always_comb begin
        pc_f_d         = pc_f_q;
        resp_pc_d      = resp_pc_q;
        resp_pending_d = 1'b0;
        if_id_d        = if_id_q;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;

        if (i_redirect_valid) begin
            pc_f_d        = pc_align(i_redirect_pc);
            if_id_d.valid = 1'b0;
            skid_clear    = 1'b1;
        end else begin
            if (accept) begin
                pc_f_d         = pc_inc(pc_f_q);
                resp_pc_d      = pc_f_q;
                resp_pending_d = 1'b1;
            end

            if (i_hazard_stall) begin
                // IF/ID holds; park a landing response in the skid
                skid_load = resp_pending_q;
            end else if (skid_valid) begin
                if_id_d.valid    = 1'b1;
                if_id_d.pc       = skid_pc;
                if_id_d.pc_plus4 = pc_inc(skid_pc);
                if_id_d.instr    = skid_instr;
                skid_clear       = 1'b1;
            end else if (resp_pending_q) begin
                if_id_d.valid    = 1'b1;
                if_id_d.pc       = resp_pc_q;
                if_id_d.pc_plus4 = pc_inc(resp_pc_q);
                if_id_d.instr    = i_imem_rdata;
            end else begin
                if_id_d.valid = 1'b0;
            end
        end
    end

    // Fetch state and IF/ID register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_f_q         <= RESET_PC;
            resp_pc_q      <= '0;
            resp_pending_q <= 1'b0;
            if_id_q        <= '0;
        end else begin
            pc_f_q         <= pc_f_d;
            resp_pc_q      <= resp_pc_d;
            resp_pending_q <= resp_pending_d;
            if_id_q        <= if_id_d;
        end
    end

    assign o_if_id_valid    = if_id_q.valid;
    assign o_if_id_pc       = if_id_q.pc;
    assign o_if_id_pc_plus4 = if_id_q.pc_plus4;
    assign o_if_id_instr    = if_id_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns ~addr one
// cycle after acceptance and a junk pattern otherwise.
module tb_fetch_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_hazard_stall;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic [31:0] i_imem_rdata;
    logic        o_if_id_valid;
    logic [31:0] o_if_id_pc;
    logic [31:0] o_if_id_pc_plus4;
    logic [31:0] o_if_id_instr;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_hazard_stall   (i_hazard_stall),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_ready     (i_imem_ready),
        .i_imem_rdata     (i_imem_rdata),
        .o_if_id_valid    (o_if_id_valid),
        .o_if_id_pc       (o_if_id_pc),
        .o_if_id_pc_plus4 (o_if_id_pc_plus4),
        .o_if_id_instr    (o_if_id_instr)
    );

    always #5 i_clk = ~i_clk;

    // Memory model: data valid exactly one cycle after acceptance
    always @(posedge i_clk) begin
        if (o_imem_req && i_imem_ready) i_imem_rdata <= ~o_imem_addr;
        else                            i_imem_rdata <= 32'hBAD0_BAD0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, ".req"}, {31'd0, o_imem_req}, {31'd0, req});
        if (req) chk({tag, ".addr"}, o_imem_addr, addr);
    endtask

    task automatic chk_if(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
        chk({tag, ".valid"}, {31'd0, o_if_id_valid}, {31'd0, v});
        if (v) begin
            chk({tag, ".pc"}, o_if_id_pc, pc);
            chk({tag, ".pc4"}, o_if_id_pc_plus4, pc + 32'd4);
            chk({tag, ".instr"}, o_if_id_instr, instr);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req"}, {31'd0, o_imem_req}, 32'd0);
        chk({tag, ".addr"}, o_imem_addr, 32'd0);
        chk({tag, ".valid"}, {31'd0, o_if_id_valid}, 32'd0);
        chk({tag, ".pc"}, o_if_id_pc, 32'd0);
        chk({tag, ".pc4"}, o_if_id_pc_plus4, 32'd0);
        chk({tag, ".instr"}, o_if_id_instr, 32'd0);
    endtask

    // One cycle: drive inputs after the falling edge, settle, return
    task automatic cyc(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge i_clk);
        i_hazard_stall   = st;
        i_redirect_valid = rv;
        i_redirect_pc    = rpc;
        i_imem_ready     = rdy;
        #1;
    endtask

    initial begin
        i_rst_n          = 1'b0;
        i_hazard_stall   = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'd0;
        i_imem_ready     = 1'b1;
        #12;
        chk_zero("reset");

        // Startup streaming
        @(negedge i_clk); i_rst_n = 1'b1; #1;
        chk_req("c0", 1, 32'h0);  chk_if("c0", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c1", 1, 32'h4); chk_if("c1", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c2", 1, 32'h8); chk_if("c2", 1, 32'h0, 32'hFFFF_FFFF);

        // 3-cycle stall with response for 0x8 landing in the skid
        cyc(1, 0, 0, 1); chk_req("c3", 0, 0); chk_if("c3", 1, 32'h4, 32'hFFFF_FFFB);
        cyc(1, 0, 0, 1); chk_req("c4", 0, 0); chk_if("c4", 1, 32'h4, 32'hFFFF_FFFB);
        cyc(1, 0, 0, 1); chk_req("c5", 0, 0); chk_if("c5", 1, 32'h4, 32'hFFFF_FFFB);
        cyc(0, 0, 0, 1); chk_req("c6", 0, 0); chk_if("c6", 1, 32'h4, 32'hFFFF_FFFB);
        cyc(0, 0, 0, 1); chk_req("c7", 1, 32'hC);  chk_if("c7", 1, 32'h8, 32'hFFFF_FFF7);
        cyc(0, 0, 0, 1); chk_req("c8", 1, 32'h10); chk_if("c8", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c9", 1, 32'h14); chk_if("c9", 1, 32'hC, 32'hFFFF_FFF3);

        // Ready pattern 1,0,0,1
        cyc(0, 0, 0, 1); chk_req("c10", 1, 32'h18); chk_if("c10", 1, 32'h10, 32'hFFFF_FFEF);
        cyc(0, 0, 0, 0); chk_req("c11", 1, 32'h1C); chk_if("c11", 1, 32'h14, 32'hFFFF_FFEB);
        cyc(0, 0, 0, 0); chk_req("c12", 1, 32'h1C); chk_if("c12", 1, 32'h18, 32'hFFFF_FFE7);
        cyc(0, 0, 0, 1); chk_req("c13", 1, 32'h1C); chk_if("c13", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c14", 1, 32'h20); chk_if("c14", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c15", 1, 32'h24); chk_if("c15", 1, 32'h1C, 32'hFFFF_FFE3);

        // Redirect (misaligned target) while stalled with skid occupied
        cyc(1, 0, 0, 1); chk_req("c16", 0, 0); chk_if("c16", 1, 32'h20, 32'hFFFF_FFDF);
        cyc(1, 1, 32'h103, 1); chk_req("c17", 0, 0); chk_if("c17", 1, 32'h20, 32'hFFFF_FFDF);
        cyc(0, 0, 0, 1); chk_req("c18", 1, 32'h100); chk_if("c18", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c19", 1, 32'h104); chk_if("c19", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c20", 1, 32'h108); chk_if("c20", 1, 32'h100, 32'hFFFF_FEFF);
        cyc(0, 0, 0, 1); chk_req("c21", 1, 32'h10C); chk_if("c21", 1, 32'h104, 32'hFFFF_FEFB);

        // Address wrap at top of memory
        cyc(0, 1, 32'hFFFF_FFFC, 1); chk_req("c22", 0, 0); chk_if("c22", 1, 32'h108, 32'hFFFF_FEF7);
        cyc(0, 0, 0, 1); chk_req("c23", 1, 32'hFFFF_FFFC); chk_if("c23", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c24", 1, 32'h0); chk_if("c24", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("c25", 1, 32'h4); chk_if("c25", 1, 32'hFFFF_FFFC, 32'h0000_0003);
        chk("c25.pc4_wrap", o_if_id_pc_plus4, 32'h0);
        cyc(0, 0, 0, 1); chk_req("c26", 1, 32'h8); chk_if("c26", 1, 32'h0, 32'hFFFF_FFFF);

        // Async reset mid-stream with skid occupied
        cyc(1, 0, 0, 1); chk_req("c27", 0, 0); chk_if("c27", 1, 32'h4, 32'hFFFF_FFFB);
        cyc(1, 0, 0, 1); chk_req("c28", 0, 0); chk_if("c28", 1, 32'h4, 32'hFFFF_FFFB);
        #2 i_rst_n = 1'b0;
        #1 chk_zero("async_rst");
        cyc(0, 0, 0, 1); chk_zero("rst_hold");
        @(negedge i_clk); i_rst_n = 1'b1; #1;
        chk_req("r0", 1, 32'h0); chk_if("r0", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("r1", 1, 32'h4); chk_if("r1", 0, 0, 0);
        cyc(0, 0, 0, 1); chk_req("r2", 1, 32'h8); chk_if("r2", 1, 32'h0, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 1); chk_if("r3", 1, 32'h4, 32'hFFFF_FFFB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
